// File: rtl/lb_mdio_pkg.sv
// Shared Clause-22 MDIO constants, FSM state type and frame helper.
package lb_mdio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_HEADER   = 3'd2,
    ST_TA       = 3'd3,
    ST_DATA     = 3'd4,
    ST_DONE     = 3'd5
  } mdio_state_e;

  localparam logic [1:0] MDIO_ST       = 2'b01;
  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;
  localparam logic [1:0] MDIO_TA_WRITE = 2'b10;

  // Index of the last bit inside each fixed-length frame section.
  localparam logic [5:0] HDR_LAST  = 6'd13;
  localparam logic [5:0] TA_LAST   = 6'd1;
  localparam logic [5:0] DATA_LAST = 6'd15;

  // ST + OP + PHYAD + REGAD, transmitted MSB first.
  function automatic logic [13:0] mdio_header(input logic       wr,
                                              input logic [4:0] phy,
                                              input logic [4:0] regad);
    mdio_header = {MDIO_ST, (wr ? MDIO_OP_WRITE : MDIO_OP_READ), phy, regad};
  endfunction

endpackage

// File: rtl/mdio_clk_en.sv
// MDC generator: half-period counter with rise/fall strobes, MDC held low when not running.
module mdio_clk_en #(
  parameter int unsigned ClkDiv = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic mdc_o,
  output logic rise_o,
  output logic fall_o
);

  logic [7:0] hp_cnt_q;
  logic       mdc_q;
  logic       tick_s;

  assign tick_s = run_i && (hp_cnt_q == 8'(ClkDiv - 1));
  assign rise_o = tick_s && !mdc_q;
  assign fall_o = tick_s && mdc_q;
  assign mdc_o  = mdc_q;

  // Half-period counter and MDC toggle; a stopped generator restarts from a clean low phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      hp_cnt_q <= 8'd0;
      mdc_q    <= 1'b0;
    end else if (!run_i) begin
      hp_cnt_q <= 8'd0;
      mdc_q    <= 1'b0;
    end else if (tick_s) begin
      hp_cnt_q <= 8'd0;
      mdc_q    <= !mdc_q;
    end else begin
      hp_cnt_q <= hp_cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one command in, one framed MDC/MDIO transaction out, one response back.
module mdio_master
  import lb_mdio_pkg::*;
#(
  parameter int unsigned ClkDiv      = 10,
  parameter int unsigned PreambleLen = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic        mdio_mdc,
  output logic        mdio_out,
  output logic        mdio_oen,
  input  logic        mdio_in
);

  localparam logic [5:0] PRE_LAST = (PreambleLen == 0) ? 6'd0 : 6'(PreambleLen - 1);
  localparam mdio_state_e START_ST = (PreambleLen == 0) ? ST_HEADER : ST_PREAMBLE;

  mdio_state_e state_q, state_d, next_sec_s;
  logic [5:0]  bit_cnt_q, bit_cnt_d, last_s;
  logic        write_q, write_d;
  logic [4:0]  phy_q, phy_d, reg_q, reg_d;
  logic [15:0] wdata_q, wdata_d, shift_q, shift_d, rdata_q, rdata_d;
  logic        out_q, out_d, oen_q, oen_d;
  logic        rsp_valid_q, rsp_valid_d, busy_q, busy_d;
  logic        run_q, sync1_q, sync2_q;
  logic        in_frame_s, rise_s, fall_s;

  // {oen, out} for a given frame position; released bits idle high.
  function automatic logic [1:0] frame_bit(input mdio_state_e st, input logic [3:0] cnt,
                                           input logic wr, input logic [13:0] hdr,
                                           input logic [15:0] wd);
    logic [1:0] r;
    r = 2'b11;
    case (st)
      ST_PREAMBLE: r = 2'b01;
      ST_HEADER:   r = {1'b0, hdr[4'd13 - cnt]};
      ST_TA:       r = wr ? {1'b0, MDIO_TA_WRITE[~cnt[0]]} : 2'b11;
      ST_DATA:     r = wr ? {1'b0, wd[4'd15 - cnt]} : 2'b11;
      default:     r = 2'b11;
    endcase
    return r;
  endfunction

  assign in_frame_s = (state_q == ST_PREAMBLE) || (state_q == ST_HEADER) ||
                      (state_q == ST_TA) || (state_q == ST_DATA);
  assign cmd_ready  = (state_q == ST_IDLE) && !rst;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign busy       = busy_q;
  assign mdio_out   = out_q;
  assign mdio_oen   = oen_q;

  mdio_clk_en #(.ClkDiv(ClkDiv)) u_clk_en (
    .clk    (clk),
    .rst    (rst),
    .run_i  (run_q),
    .mdc_o  (mdio_mdc),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  // Length and successor of the frame section currently being shifted.
  always_comb begin
    last_s     = 6'd0;
    next_sec_s = ST_IDLE;
    case (state_q)
      ST_PREAMBLE: begin last_s = PRE_LAST;  next_sec_s = ST_HEADER; end
      ST_HEADER:   begin last_s = HDR_LAST;  next_sec_s = ST_TA;     end
      ST_TA:       begin last_s = TA_LAST;   next_sec_s = ST_DATA;   end
      ST_DATA:     begin last_s = DATA_LAST; next_sec_s = ST_DONE;   end
      default:     begin last_s = 6'd0;      next_sec_s = ST_IDLE;   end
    endcase
  end

  // Next-state logic: accept, advance one bit per MDC fall, sample on MDC rise, respond.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    write_d     = write_q;
    phy_d       = phy_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    rdata_d     = rdata_q;
    out_d       = out_q;
    oen_d       = oen_q;
    rsp_valid_d = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          write_d   = cmd_write;
          phy_d     = cmd_phy_addr;
          reg_d     = cmd_reg_addr;
          wdata_d   = cmd_wdata;
          shift_d   = 16'd0;
          state_d   = START_ST;
          bit_cnt_d = 6'd0;
          busy_d    = 1'b1;
          {oen_d, out_d} = frame_bit(START_ST, 4'd0, cmd_write,
                                     mdio_header(cmd_write, cmd_phy_addr, cmd_reg_addr),
                                     cmd_wdata);
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_PREAMBLE, ST_HEADER, ST_TA, ST_DATA: begin
        if (rise_s && (state_q == ST_DATA) && !write_q) begin
          shift_d = {shift_q[14:0], sync2_q};
        end else begin
          shift_d = shift_q;
        end
        if (fall_s) begin
          if (bit_cnt_q == last_s) begin
            state_d   = next_sec_s;
            bit_cnt_d = 6'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
          if (state_d == ST_DONE) begin
            out_d       = 1'b1;
            oen_d       = 1'b1;
            rsp_valid_d = 1'b1;
            rdata_d     = write_q ? 16'd0 : shift_q;
          end else begin
            {oen_d, out_d} = frame_bit(state_d, bit_cnt_d[3:0], write_q,
                                       mdio_header(write_q, phy_q, reg_q), wdata_q);
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        out_d   = 1'b1;
        oen_d   = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers; the MDIO pad is double-synchronised.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 6'd0;
      write_q     <= 1'b0;
      phy_q       <= 5'd0;
      reg_q       <= 5'd0;
      wdata_q     <= 16'd0;
      shift_q     <= 16'd0;
      rdata_q     <= 16'd0;
      out_q       <= 1'b1;
      oen_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      run_q       <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      write_q     <= write_d;
      phy_q       <= phy_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      rdata_q     <= rdata_d;
      out_q       <= out_d;
      oen_q       <= oen_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      run_q       <= in_frame_s;
      sync1_q     <= mdio_in;
      sync2_q     <= sync1_q;
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench: dut0 (ClkDiv=2, 32-bit preamble) and dut1 (ClkDiv=2, no preamble).
module tb_mdio_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v0 = 1'b0, w0 = 1'b0, rdy0, rv0, busy0, mdc0, mout0, moen0;
  logic        min0 = 1'b1;
  logic [4:0]  pa0 = 5'd0, ra0 = 5'd0;
  logic [15:0] wd0 = 16'd0, rd0;
  logic        v1 = 1'b0, w1 = 1'b0, rdy1, rv1, busy1, mdc1, mout1, moen1;
  logic        min1 = 1'b1;
  logic [4:0]  pa1 = 5'd0, ra1 = 5'd0;
  logic [15:0] wd1 = 16'd0, rd1;

  mdio_master #(.ClkDiv(2), .PreambleLen(32)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(v0), .cmd_ready(rdy0), .cmd_write(w0),
    .cmd_phy_addr(pa0), .cmd_reg_addr(ra0), .cmd_wdata(wd0), .rsp_valid(rv0),
    .rsp_rdata(rd0), .busy(busy0), .mdio_mdc(mdc0), .mdio_out(mout0),
    .mdio_oen(moen0), .mdio_in(min0));

  mdio_master #(.ClkDiv(2), .PreambleLen(0)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_write(w1),
    .cmd_phy_addr(pa1), .cmd_reg_addr(ra1), .cmd_wdata(wd1), .rsp_valid(rv1),
    .rsp_rdata(rd1), .busy(busy1), .mdio_mdc(mdc1), .mdio_out(mout1),
    .mdio_oen(moen1), .mdio_in(min1));

  int compared = 0;
  int mismatched = 0;

  // Monitor / PHY model state (written only by the monitors).
  int cyc = 0, rises0 = 0, rises1 = 0, last_rise0 = 0, period0 = 0, hi_len0 = 0, rsp_cnt0 = 0;
  logic mdc0_prev = 1'b0, mdc1_prev = 1'b0;
  logic [63:0] cap0 = 64'd0, capoen0 = 64'd0, cap1 = 64'd0;
  // PHY model controls (written only by the stimulus).
  int phy_base0 = 0, phy_base1 = 0;
  logic [15:0] phy_data0 = 16'd0, phy_data1 = 16'd0;

  // dut0 monitor: captures bits at MDC rise, measures MDC timing, PHY drives read data after each rise.
  always @(negedge clk) begin
    int rel;
    cyc = cyc + 1;
    if (rv0) rsp_cnt0 = rsp_cnt0 + 1;
    if (mdc0 && !mdc0_prev) begin
      rises0     = rises0 + 1;
      cap0       = {cap0[62:0], mout0};
      capoen0    = {capoen0[62:0], moen0};
      period0    = cyc - last_rise0;
      last_rise0 = cyc;
      rel        = rises0 - phy_base0;
      if (rel >= 48 && rel < 64) min0 = phy_data0[15 - (rel - 48)];
      else                       min0 = 1'b1;
    end
    if (!mdc0 && mdc0_prev) hi_len0 = cyc - last_rise0;
    mdc0_prev = mdc0;
  end

  // dut1 monitor and PHY model (no preamble: data follows rise 16).
  always @(negedge clk) begin
    int rel;
    if (mdc1 && !mdc1_prev) begin
      rises1 = rises1 + 1;
      cap1   = {cap1[62:0], mout1};
      rel    = rises1 - phy_base1;
      if (rel >= 16 && rel < 32) min1 = phy_data1[15 - (rel - 16)];
      else                       min1 = 1'b1;
    end
    mdc1_prev = mdc1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared = compared + 1;
    assert (got === exp) else begin
      mismatched = mismatched + 1;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called on the negedge right after the accept edge; n = edges from accept to rsp_valid.
  task automatic wait_rsp0(output int n, output int rdy_seen);
    n = 0; rdy_seen = 0;
    while (!rv0 && n < 2000) begin
      @(negedge clk);
      n = n + 1;
      if (rdy0) rdy_seen = rdy_seen + 1;
    end
  endtask

  task automatic wait_rsp1(output int n);
    n = 0;
    while (!rv1 && n < 2000) begin
      @(negedge clk);
      n = n + 1;
    end
  endtask

  initial begin
    int n, rdy, r0, rc;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(rdy0), 64'd0);
    check("rst_mdc",   64'(mdc0), 64'd0);
    check("rst_oen",   64'(moen0), 64'd1);
    check("rst_out",   64'(mout0), 64'd1);
    check("rst_rsp",   64'(rv0), 64'd0);
    check("rst_rdata", 64'(rd0), 64'd0);
    check("rst_busy",  64'(busy0), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(rdy0), 64'd1);

    // Write phy=1 reg=0 data=0x1140.
    w0 = 1'b1; pa0 = 5'd1; ra0 = 5'd0; wd0 = 16'h1140; v0 = 1'b1;
    r0 = rises0;
    @(negedge clk);
    v0 = 1'b0;
    check("wr_busy", 64'(busy0), 64'd1);
    check("wr_ready_low", 64'(rdy0), 64'd0);
    wait_rsp0(n, rdy);
    check("wr_latency", 64'(n), 64'd257);
    check("wr_rdata_zero", 64'(rd0), 64'd0);
    check("wr_busy_at_rsp", 64'(busy0), 64'd1);
    check("wr_bits", 64'(rises0 - r0), 64'd64);
    check("wr_frame", cap0, 64'hFFFF_FFFF_5082_1140);
    check("wr_oen", capoen0, 64'h0);
    check("mdc_period", 64'(period0), 64'd4);
    check("mdc_high", 64'(hi_len0), 64'd2);
    check("done_mdc", 64'(mdc0), 64'd0);
    check("done_oen", 64'(moen0), 64'd1);
    check("done_out", 64'(mout0), 64'd1);
    @(negedge clk);
    check("rsp_one_cycle", 64'(rv0), 64'd0);
    check("idle_busy", 64'(busy0), 64'd0);
    check("idle_ready", 64'(rdy0), 64'd1);

    // Read phy=1 reg=2, PHY returns 0x0141.
    phy_data0 = 16'h0141; phy_base0 = rises0;
    w0 = 1'b0; pa0 = 5'd1; ra0 = 5'd2; wd0 = 16'hFFFF; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    wait_rsp0(n, rdy);
    check("rd_latency", 64'(n), 64'd257);
    check("rd_rdata", 64'(rd0), 64'h0141);
    check("rd_header", 64'(cap0[63:18]), {18'd0, 32'hFFFF_FFFF, 14'b01_10_00001_00010});
    check("rd_oen", capoen0, 64'h0000_0000_0003_FFFF);
    @(negedge clk);

    // cmd_valid held through a write; fields changed after accept.
    w0 = 1'b1; pa0 = 5'd3; ra0 = 5'd4; wd0 = 16'hA5A5; v0 = 1'b1;
    @(negedge clk);
    w0 = 1'b0; pa0 = 5'd5; ra0 = 5'd6; wd0 = 16'h0000;
    phy_data0 = 16'hBEEF;
    wait_rsp0(n, rdy);
    check("b2b_first_latency", 64'(n), 64'd257);
    check("b2b_no_early_accept", 64'(rdy), 64'd0);
    check("b2b_first_frame", cap0, 64'hFFFF_FFFF_5192_A5A5);
    check("b2b_ready_in_done", 64'(rdy0), 64'd0);
    @(negedge clk);
    check("b2b_ready_idle", 64'(rdy0), 64'd1);
    phy_base0 = rises0;
    @(negedge clk);
    v0 = 1'b0;
    check("b2b_second_busy", 64'(busy0), 64'd1);
    check("b2b_second_ready", 64'(rdy0), 64'd0);
    wait_rsp0(n, rdy);
    check("b2b_second_latency", 64'(n), 64'd257);
    check("b2b_second_rdata", 64'(rd0), 64'hBEEF);
    check("b2b_second_header", 64'(cap0[63:18]), {18'd0, 32'hFFFF_FFFF, 14'b01_10_00101_00110});
    @(negedge clk);

    // Reset at bit 40 of a write.
    w0 = 1'b1; pa0 = 5'd1; ra0 = 5'd0; wd0 = 16'h1140; v0 = 1'b1;
    r0 = rises0;
    @(negedge clk);
    v0 = 1'b0;
    n = 0;
    while ((rises0 - r0) < 40 && n < 2000) begin
      @(negedge clk);
      n = n + 1;
    end
    check("abort_reached_bit40", 64'(rises0 - r0 >= 40), 64'd1);
    rc = rsp_cnt0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_mdc", 64'(mdc0), 64'd0);
    check("abort_oen", 64'(moen0), 64'd1);
    check("abort_out", 64'(mout0), 64'd1);
    check("abort_ready_in_rst", 64'(rdy0), 64'd0);
    check("abort_busy", 64'(busy0), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 64'(rdy0), 64'd1);
    r0 = rises0;
    repeat (300) @(negedge clk);
    check("abort_no_rsp", 64'(rsp_cnt0 - rc), 64'd0);
    check("abort_mdc_idle", 64'(rises0 - r0), 64'd0);

    // dut1 (no preamble): read phy=31 reg=31 returning 0xFFFF, then 0x8421.
    phy_data1 = 16'hFFFF; phy_base1 = rises1;
    w1 = 1'b0; pa1 = 5'd31; ra1 = 5'd31; v1 = 1'b1;
    r0 = rises1;
    @(negedge clk);
    v1 = 1'b0;
    wait_rsp1(n);
    check("p0_latency", 64'(n), 64'd129);
    check("p0_rdata", 64'(rd1), 64'hFFFF);
    check("p0_bits", 64'(rises1 - r0), 64'd32);
    check("p0_header", 64'(cap1[31:18]), 64'(14'b01_10_11111_11111));
    @(negedge clk);
    phy_data1 = 16'h8421; phy_base1 = rises1;
    pa1 = 5'd0; ra1 = 5'd1; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    wait_rsp1(n);
    check("p0_latency2", 64'(n), 64'd129);
    check("p0_rdata2", 64'(rd1), 64'h8421);
    check("p0_header2", 64'(cap1[31:18]), 64'(14'b01_10_00000_00001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mdio_master.md
MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 SHALL have parameter ClkDiv, default 10, giving sys-clock cycles per MDC half-period (legal range 2..255).
REQ-002 SHALL have parameter PreambleLen, default 32, giving the number of preamble '1' bits (legal range 0..32).
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when valid&ready.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_phy_addr  input  5  PHY address.
REQ-009 cmd_reg_addr  input  5  register address.
REQ-010 cmd_wdata  input  16  write data.
REQ-011 rsp_valid  output  1  one-cycle pulse at transaction end (read and write).
REQ-012 rsp_rdata  output  16  read data, valid with rsp_valid (0 for writes).
REQ-013 busy  output  1  high from accept until rsp_valid inclusive.
REQ-014 mdio_mdc  output  1  management clock to PHY.
REQ-015 mdio_out  output  1  MDIO drive value.
REQ-016 mdio_oen  output  1  1 = release MDIO (tristate), 0 = drive mdio_out.
REQ-017 mdio_in  input  1  MDIO pad sample (asynchronous; 2-flop synchronised internally).

Function
REQ-018 SHALL generate Clause-22 frames: preamble, ST=01, OP (01 write / 10 read), PHYAD[4:0] MSB first, REGAD[4:0] MSB first, TA, DATA[15:0] MSB first.
REQ-019 SHALL keep MDC low while idle; active MDC period SHALL be 2*ClkDiv clk cycles, 50% duty.
REQ-020 SHALL update mdio_out/mdio_oen only on the clk cycle where MDC falls (or on frame start, with MDC low).
REQ-021 SHALL sample the synchronised mdio_in on the clk cycle where MDC rises.
REQ-022 FSM states: IDLE, PREAMBLE, HEADER (ST+OP+PHYAD+REGAD, 14 bits), TA, DATA, DONE.
REQ-023 IDLE: cmd_ready=1; on valid&ready, latch all cmd_* fields, then go to PREAMBLE (HEADER if PreambleLen=0).
REQ-024 Write TA SHALL drive "10"; read TA SHALL release MDIO for both bits (oen=1) and ignore the sampled value.
REQ-025 Reads SHALL keep oen=1 through DATA and shift 16 sampled bits MSB first into rsp_rdata.
REQ-026 A 6-bit counter SHALL count bits within each state; transitions occur after the last bit's MDC high half completes.
REQ-027 DONE: MDC low, oen=1, mdio_out=1, rsp_valid=1 for exactly one cycle, then IDLE.
REQ-028 cmd_ready SHALL be 0 in every state except IDLE; cmd_valid outside IDLE SHALL be ignored with no side effects.
REQ-029 Latency, accept to rsp_valid: (PreambleLen+32)*2*ClkDiv + 1 clk cycles.
REQ-030 Back-to-back: a command presented during DONE SHALL be accepted on the IDLE cycle immediately after it.

Reset
REQ-031 On rst: state=IDLE, mdio_mdc=0, mdio_oen=1, mdio_out=1, rsp_valid=0, rsp_rdata=0, busy=0, cmd_ready=0 during rst and 1 on the first cycle after rst.
REQ-032 rst mid-frame SHALL abort the frame immediately and issue no rsp_valid.

Structure
REQ-033 OP codes (01/10), ST pattern and TA-write pattern SHALL be constants in shared package lb_mdio_pkg.
REQ-034 MDC tick generation (half-period counter producing rise/fall strobes) SHALL be sub-module mdio_clk_en; FSM and shift register SHALL stay in mdio_master.

Verification
REQ-035 ClkDiv=2, write phy=1 reg=0 data=0x1140 -> MDC period 4 clk; 64 bits observed at MDC rising edges = 32x'1',01,01,00001,00000,10,0x1140; rsp_valid after 257 clk.
REQ-036 Read phy=1 reg=2, PHY model drives 0x0141 after TA -> oen=1 from TA onward, rsp_rdata=0x0141 with rsp_valid.
REQ-037 cmd_valid held high through one transaction with different fields -> second command accepted only on the cycle after DONE; fields captured at accept unaffected.
REQ-038 rst asserted at bit 40 of a write -> next cycle MDC=0, oen=1, out=1, cmd_ready=1 the cycle after rst deasserts, no rsp_valid.
REQ-039 PreambleLen=0, read phy=31 reg=31, PHY returns 0xFFFF -> 32-bit frame, rsp_rdata=0xFFFF, latency 129 clk at ClkDiv=2.
